// File: rtl/rx_2_if.sv
// Frame-receive and DDR-write bus bundle for rx_2: TSE Avalon-ST receive sink plus
// Avalon-MM write master. The DUT uses the master view, the environment the slave view.
interface rx_2_if;
  logic [7:0]   ff_rx_data;
  logic         ff_rx_sop;
  logic         ff_rx_eop;
  logic         ff_rx_err;
  logic         ff_rx_dval;
  logic         ff_rx_rdy;
  logic [24:0]  amm_addr;
  logic [255:0] amm_writedata;
  logic [31:0]  amm_byteenable;
  logic [6:0]   amm_burstcount;
  logic         amm_write;
  logic         amm_read;
  logic         amm_ready;

  modport master (
    input  ff_rx_data, ff_rx_sop, ff_rx_eop, ff_rx_err, ff_rx_dval,
    output ff_rx_rdy,
    output amm_addr, amm_writedata, amm_byteenable, amm_burstcount, amm_write, amm_read,
    input  amm_ready
  );

  modport slave (
    output ff_rx_data, ff_rx_sop, ff_rx_eop, ff_rx_err, ff_rx_dval,
    input  ff_rx_rdy,
    input  amm_addr, amm_writedata, amm_byteenable, amm_burstcount, amm_write, amm_read,
    output amm_ready
  );
endinterface

// File: rtl/rx_2.sv
// Receive-side DMA writer: packs one Ethernet frame into 256-bit words and writes them
// to DDR through a single write-hold register backed by one accumulator.
module rx_2 #(
  parameter int unsigned MAX_FRAME_BYTES = 1536
) (
  input  logic        avalon_clk,
  input  logic        rst_n,
  rx_2_if.master      bus,
  input  logic [24:0] start_ram_addr,
  input  logic        cmd_recv,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_len,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, WAIT_SOP, RECV, FLUSH} state_t;

  localparam logic [15:0] MAX_BYTES = 16'(MAX_FRAME_BYTES);

  state_t       state;
  logic [255:0] acc_data;
  logic [5:0]   acc_cnt;
  logic         acc_full;
  logic [15:0]  byte_cnt;
  logic         trunc;
  logic         err_q;

  logic [255:0] acc_nxt;
  logic [5:0]   cnt_nxt;
  logic         accept;
  logic         frame_byte;
  logic         store;
  logic         last;
  logic         close;
  logic         pending;
  logic         hold_free;
  logic         load;
  logic         acc_full_nxt;
  logic         flush_done;

  function automatic logic [31:0] lane_mask(input logic [5:0] n);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) m[i] = (i < 32'(n));
    return m;
  endfunction

  assign bus.amm_burstcount = 7'd1;
  assign bus.amm_read       = 1'b0;

  always_comb begin
    accept     = bus.ff_rx_dval && bus.ff_rx_rdy;
    frame_byte = accept && ((state == WAIT_SOP && bus.ff_rx_sop) || state == RECV);
    store      = frame_byte && (byte_cnt < MAX_BYTES);
    last       = frame_byte && bus.ff_rx_eop;

    acc_nxt = acc_data;
    if (store) acc_nxt[{byte_cnt[4:0], 3'b000} +: 8] = bus.ff_rx_data;
    cnt_nxt = acc_cnt + {5'd0, store};

    // An eop that lands after truncation with nothing buffered closes no word.
    close        = !acc_full && ((cnt_nxt == 6'd32) || (last && cnt_nxt != 6'd0));
    pending      = acc_full || close;
    hold_free    = !bus.amm_write || bus.amm_ready;
    load         = pending && hold_free;
    acc_full_nxt = pending && !hold_free;
    flush_done   = (state == FLUSH) && (acc_cnt == 6'd0) && !acc_full && hold_free;
  end

  always_ff @(posedge avalon_clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      acc_data           <= '0;
      acc_cnt            <= '0;
      acc_full           <= 1'b0;
      byte_cnt           <= '0;
      trunc              <= 1'b0;
      err_q              <= 1'b0;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      frame_len          <= '0;
      frame_err          <= 1'b0;
      bus.ff_rx_rdy      <= 1'b0;
      bus.amm_write      <= 1'b0;
      bus.amm_addr       <= '0;
      bus.amm_writedata  <= '0;
      bus.amm_byteenable <= '0;
    end else begin
      frame_done    <= 1'b0;
      bus.ff_rx_rdy <= !acc_full_nxt;

      if (bus.amm_write && bus.amm_ready) bus.amm_addr <= bus.amm_addr + 25'd1;

      if (load) begin
        bus.amm_write      <= 1'b1;
        bus.amm_writedata  <= acc_nxt;
        bus.amm_byteenable <= lane_mask(cnt_nxt);
      end else if (bus.amm_ready) begin
        bus.amm_write <= 1'b0;
      end

      if (load) begin
        acc_data <= '0;
        acc_cnt  <= '0;
      end else begin
        acc_data <= acc_nxt;
        acc_cnt  <= cnt_nxt;
      end
      acc_full <= acc_full_nxt;

      byte_cnt <= byte_cnt + {15'd0, store};
      if (frame_byte && !store) trunc <= 1'b1;
      if (last) err_q <= bus.ff_rx_err;

      case (state)
        IDLE: begin
          if (cmd_recv) begin
            bus.amm_addr <= start_ram_addr;
            byte_cnt     <= '0;
            trunc        <= 1'b0;
            err_q        <= 1'b0;
            busy         <= 1'b1;
            state        <= WAIT_SOP;
          end
        end
        WAIT_SOP: begin
          if (frame_byte) state <= last ? FLUSH : RECV;
        end
        RECV: begin
          if (last) state <= FLUSH;
        end
        FLUSH: begin
          if (flush_done) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            frame_len  <= byte_cnt;
            frame_err  <= err_q || trunc;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rx_2.md
# rx_2

Receive-side DMA writer paired with the `tx_2` transmit reader. Accepts one Ethernet frame from the TSE receive FIFO interface (Avalon-ST sink, 8-bit), packs its bytes into 256-bit words and writes them to DDR through an Avalon-MM master, starting at a software-supplied word address. Reports frame length and error status on completion. Single clock domain; any clock crossing sits outside this block.

## Interface
- `MAX_FRAME_BYTES`, 1536: bytes stored per frame; excess bytes are accepted and dropped, and `frame_err` is set.
- `avalon_clk`  in  1  block clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ff_rx_data`  in  8  frame byte.
- `ff_rx_sop`  in  1  first byte of frame.
- `ff_rx_eop`  in  1  last byte of frame.
- `ff_rx_err`  in  1  error flag, sampled with the eop byte.
- `ff_rx_dval`  in  1  byte valid.
- `ff_rx_rdy`  out  1  sink ready.
- `amm_addr`  out  25  DDR word address.
- `amm_writedata`  out  256  write data; byte k on bits [8k+7:8k].
- `amm_byteenable`  out  32  lane enables.
- `amm_burstcount`  out  7  constant 1.
- `amm_write`  out  1  write request.
- `amm_read`  out  1  constant 0.
- `amm_ready`  in  1  write accepted when high together with `amm_write`.
- `start_ram_addr`  in  25  first word address, captured on `cmd_recv`.
- `cmd_recv`  in  1  one-cycle arm pulse.
- `busy`  out  1  high from arm until `frame_done`.
- `frame_done`  out  1  one-cycle completion pulse.
- `frame_len`  out  16  bytes stored for the last frame; valid from `frame_done`.
- `frame_err`  out  1  `ff_rx_err` at eop, OR truncation; valid from `frame_done`.

## Operation
- A byte is accepted on any cycle where `ff_rx_dval && ff_rx_rdy`.
- States:
  - IDLE: accepted bytes are discarded. `cmd_recv` captures `start_ram_addr` into the address counter, clears the byte counter, and moves to WAIT_SOP.
  - WAIT_SOP: accepted bytes without `sop` are discarded. An accepted `sop` byte is stored in lane 0 and moves to RECV. If that byte also carries `eop`, go directly to FLUSH.
  - RECV: each accepted byte is stored in lane `byte_cnt[4:0]`. `sop` is ignored and treated as data. Accepted `eop` moves to FLUSH.
  - FLUSH: wait until the accumulator and hold registers are both empty, then pulse `frame_done` and return to IDLE.
- `cmd_recv` is ignored outside IDLE.
- Buffering uses two registers: an accumulator and a write-hold register.
  - A word closes on its 32nd byte or on `eop`.
  - A closed word moves into hold if hold is empty or is being accepted this cycle. Otherwise the accumulator sets `acc_full`.
  - `ff_rx_rdy` is low during reset, and equals `!acc_full` after reset.
- Hold contents drive `amm_write`, `amm_addr`, `amm_writedata` and `amm_byteenable`.
  - Byteenable is all-ones for a full word. For a partial last word with n bytes, the low n bits are 1.
  - Unused data lanes are 0.
  - `amm_addr` increments by 1 after each accepted write.
- Byte counter saturates at `MAX_FRAME_BYTES`. Bytes beyond it are accepted (rdy unaffected) but not stored, and set a sticky truncation flag. `frame_len` = stored byte count.
- Reset values:
  - `ff_rx_rdy`, `amm_write`, `busy`, `frame_done`, `frame_err`: 0.
  - `amm_addr`, `amm_writedata`, `amm_byteenable`, `frame_len`: 0.
  - `amm_burstcount`: 1.
  - state: IDLE.

## Timing
- 32nd byte or `eop` accepted in cycle N with hold free: `amm_write` is high in cycle N+1.
- While `amm_write && !amm_ready`, `amm_write`, `amm_addr`, `amm_writedata` and `amm_byteenable` are held stable. No write is dropped or duplicated.
- Word closes while hold is busy: `acc_full` is set at edge N, `ff_rx_rdy` is low from N+1, and the move into hold happens on the cycle hold is accepted.
- `frame_done` is asserted in the cycle after the last write is accepted. `busy` falls in the same cycle.
- `frame_len` and `frame_err` update with `frame_done` and hold until the next `frame_done`.
- Reset asserted mid-frame or mid-write: all state clears at the next edge. `amm_write` drops even if the write is unaccepted; the partial frame is abandoned and no `frame_done` is issued.
- Sustained throughput: 1 byte/cycle while `amm_ready` is high at least 1 cycle in 32.

## Test plan
- Arm at 0x0000100 and send a 64-byte frame with `amm_ready` high: two writes at 0x100 and 0x101, byteenable 0xFFFFFFFF, bytes in order from lane 0. Then `frame_len`=64, `frame_err`=0, one `frame_done` pulse.
- Arm at 0x0000200 and send a 33-byte frame with `ff_rx_err`=1 on eop: second write at 0x201 has byteenable 0x00000001 and data bits [255:8]=0. Then `frame_len`=33, `frame_err`=1.
- 96-byte frame with `amm_ready` low for 40 cycles after the first write request: write signals stay stable, `ff_rx_rdy` drops after the second word closes, no bytes are lost, and three writes complete.
- Send bytes while unarmed, then arm mid-frame with no `sop`: no writes occur. The next `sop` frame is stored starting at the captured address.
- 1600-byte frame with default `MAX_FRAME_BYTES`: 48 writes, `frame_len`=1536, `frame_err`=1, `ff_rx_rdy` never blocked by truncation.
- Assert `rst_n`=0 while `amm_write` is high and `amm_ready` is low: next edge gives `amm_write`=0, `ff_rx_rdy`=0, `busy`=0, and no `frame_done`.
